// File: rtl/simon64_128_key_unschedule.sv
// SIMON64/128 reverse round-key generator: expands forward to k40..k43,
// then emits k43..k0 over a valid/ready handshake using the inverse recurrence.
// Ports: clk, rst (sync, active-high), key_in[127:0], key_load,
//        busy, rk_out[31:0], rk_idx[5:0], rk_valid, rk_ready, done,
//        load_err (only when SIMON_KS_RESTART_EN is defined).
// Macro SIMON_KS_RESTART_EN: key_load while busy aborts and reloads.
module simon64_128_key_unschedule #(
    parameter int                WIDTH   = 32,
    parameter int                ROUNDS  = 44,
    parameter logic [WIDTH-1:0]  C_CONST = 32'hFFFF_FFFC,
    parameter logic [63:0]       Z_SEQ   = 64'hFC2C_E512_07A6_35DB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] key_in,
    input  logic               key_load,
    output logic               busy,
    output logic [WIDTH-1:0]   rk_out,
    output logic [5:0]         rk_idx,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic               done
`ifdef SIMON_KS_RESTART_EN
    ,
    output logic               load_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        UNROLL = 2'd2
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 5);
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] w0, w1, w2, w3;
    logic [5:0]       cnt;
    logic [5:0]       idx;
    logic [5:0]       idx_m4;
    logic [WIDTH-1:0] fwd_new;
    logic [WIDTH-1:0] bwd_prev;
    logic             xfer;
    logic             load_acc;

    function automatic logic [WIDTH-1:0] ror(
        input logic [WIDTH-1:0] x,
        input int               r
    );
        return (x >> r) | (x << (WIDTH - r));
    endfunction

    function automatic logic [WIDTH-1:0] f_mix(input logic [WIDTH-1:0] x);
        return x ^ ror(x, 1);
    endfunction

    // Forward step yields k[i+4]; backward step recovers k[idx-4] from
    // the window k[idx-3..idx] by solving the same recurrence for k[i].
    always_comb begin
        idx_m4   = idx - 6'd4;
        fwd_new  = C_CONST ^ {{(WIDTH-1){1'b0}}, Z_SEQ[cnt]}
                 ^ w0 ^ f_mix(ror(w3, 3) ^ w1);
        bwd_prev = w3 ^ C_CONST ^ {{(WIDTH-1){1'b0}}, Z_SEQ[idx_m4]}
                 ^ f_mix(ror(w2, 3) ^ w0);
    end

    // A load is taken from IDLE always; with restart enabled it also
    // preempts a running schedule.
    always_comb begin
`ifdef SIMON_KS_RESTART_EN
        load_acc = key_load;
`else
        load_acc = key_load && (state == IDLE);
`endif
    end

    assign xfer = rk_valid & rk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_acc) begin
            state_next = EXPAND;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                EXPAND:  if (cnt == LAST_CNT) state_next = UNROLL;
                UNROLL:  if (xfer && idx == 6'd0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        rk_valid = (state == UNROLL);
        rk_out   = rk_valid ? w3 : '0;
        rk_idx   = rk_valid ? idx : 6'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w0   <= '0;
            w1   <= '0;
            w2   <= '0;
            w3   <= '0;
            cnt  <= '0;
            idx  <= '0;
            done <= 1'b0;
`ifdef SIMON_KS_RESTART_EN
            load_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SIMON_KS_RESTART_EN
            load_err <= 1'b0;
`endif
            if (load_acc) begin
                w0  <= key_in[WIDTH-1:0];
                w1  <= key_in[2*WIDTH-1:WIDTH];
                w2  <= key_in[3*WIDTH-1:2*WIDTH];
                w3  <= key_in[4*WIDTH-1:3*WIDTH];
                cnt <= '0;
`ifdef SIMON_KS_RESTART_EN
                load_err <= (state != IDLE);
`endif
            end else begin
                case (state)
                    EXPAND: begin
                        w0  <= w1;
                        w1  <= w2;
                        w2  <= w3;
                        w3  <= fwd_new;
                        cnt <= cnt + 6'd1;
                        if (cnt == LAST_CNT) idx <= LAST_IDX;
                    end
                    UNROLL: begin
                        if (xfer) begin
                            if (idx == 6'd0) begin
                                done <= 1'b1;
                            end else begin
                                w3  <= w2;
                                w2  <= w1;
                                w1  <= w0;
                                // below idx 4 the bottom slot is never read again
                                if (idx >= 6'd4) w0 <= bwd_prev;
                                idx <= idx - 6'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon64_128_key_unschedule.sv
// Self-checking bench for simon64_128_key_unschedule: reference schedule
// array, known-answer, backpressure, latency, mid-run reset, load-while-busy.
module tb_simon64_128_key_unschedule;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic [31:0]  rk_out;
    logic [5:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         done;
`ifdef SIMON_KS_RESTART_EN
    logic         load_err;
`endif

    simon64_128_key_unschedule dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
`ifdef SIMON_KS_RESTART_EN
        ,
        .load_err (load_err)
`endif
    );

    localparam logic [127:0] KAT_KEY = 128'h1B1A1918_13121110_0B0A0908_03020100;
    localparam logic [63:0]  Z3      = 64'hFC2C_E512_07A6_35DB;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_k [44];
    logic [31:0] gold  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    // Full forward key schedule, written as the usual reference loop.
    task automatic gen_ref(input logic [127:0] key);
        logic [31:0] t;
        for (int i = 0; i < 4; i++) ref_k[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = rotr(ref_k[i-1], 3) ^ ref_k[i-3];
            t = t ^ rotr(t, 1);
            ref_k[i] = ~ref_k[i-4] ^ t ^ 32'(Z3[i-4]) ^ 32'd3;
        end
    endtask

    task automatic start_load(input logic [127:0] key);
        key_in   = key;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Entered at the first sample after the load edge (edge 1 of 41).
    task automatic wait_valid();
        int n;
        n = 1;
        chk("busy_after_load", 64'(busy), 64'd1);
        while (!rk_valid && n < 100) begin
            chk("done_quiet", 64'(done), 64'd0);
            rk_ready = 1'($urandom_range(1));
            @(negedge clk);
            n++;
        end
        chk("latency_edges", 64'(n), 64'd41);
    endtask

    // Walks keys from index 'first' down; returns early (ready low) when
    // index 'stop_at' is presented.
    task automatic run(input int first, input int stop_at, input int pct,
                       input bit kat);
        int e;
        int cyc;
        e   = first;
        cyc = 0;
        while (e >= 0 && cyc < 2000) begin
            if (rk_valid) begin
                chk($sformatf("rk_idx@%0d", e), 64'(rk_idx), 64'(e));
                chk($sformatf("rk_out@%0d", e), 64'(rk_out), 64'(ref_k[e]));
                if (kat && e <= 3)
                    chk($sformatf("kat_gold@%0d", e), 64'(rk_out), 64'(gold[e]));
                if (e == stop_at) begin
                    rk_ready = 1'b0;
                    return;
                end
                rk_ready = ($urandom_range(99) < pct);
                if (rk_ready) e--;
            end else begin
                chk("valid_dropped", 64'(rk_valid), 64'd1);
                rk_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("keys_remaining", 64'(e + 1), 64'd0);
        if (e >= 0) return;
        rk_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("valid_end", 64'(rk_valid), 64'd0);
        @(negedge clk);
        chk("done_single", 64'(done), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 64'({busy, rk_valid, done, rk_out, rk_idx}), 64'd0);
`ifdef SIMON_KS_RESTART_EN
        chk({tag, "_err"}, 64'(load_err), 64'd0);
`endif
    endtask

    initial begin
        logic [127:0] key_a;
        logic [127:0] key_b;
        gold[0] = 32'h03020100;
        gold[1] = 32'h0B0A0908;
        gold[2] = 32'h13121110;
        gold[3] = 32'h1B1A1918;
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset then idle, including stray rk_ready
        for (int i = 0; i < 10; i++) begin
            rk_ready = 1'(i & 1);
            @(negedge clk);
            chk_zero("idle_zero");
        end

        // known answer, ready tied high
        gen_ref(KAT_KEY);
        start_load(KAT_KEY);
        wait_valid();
        run(43, -1, 100, 1'b1);

        // backpressure ~30%
        start_load(KAT_KEY);
        wait_valid();
        run(43, -1, 30, 1'b1);

        // random keys
        for (int r = 0; r < 2; r++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            gen_ref(key_a);
            start_load(key_a);
            wait_valid();
            run(43, -1, 60, 1'b0);
        end

        // mid-run reset at idx 20, then reload
        gen_ref(KAT_KEY);
        start_load(KAT_KEY);
        wait_valid();
        run(43, 20, 100, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("reset_abort");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_settle");
        start_load(KAT_KEY);
        wait_valid();
        run(43, -1, 100, 1'b1);

        // load while busy at idx 30
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        gen_ref(key_a);
        start_load(key_a);
        wait_valid();
        run(43, 30, 70, 1'b0);
        start_load(key_b);
`ifdef SIMON_KS_RESTART_EN
        chk("restart_err", 64'(load_err), 64'd1);
        chk("restart_valid", 64'(rk_valid), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        gen_ref(key_b);
        wait_valid();
        run(43, -1, 70, 1'b0);
`else
        chk("ignored_busy", 64'(busy), 64'd1);
        run(30, -1, 70, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
